// File: rtl/bcd_to_bin.sv
// Two-digit BCD to 7-bit binary converter.
// Reverse double-dabble over seven shift cycles, with a range check against MAX_VALUE.
module bcd_to_bin #(
  parameter int unsigned MAX_VALUE = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] BCD,
  output logic [6:0] bin,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [14:0] r_work;
  logic [2:0]  r_cnt;
  logic [6:0]  r_bin;
  logic        r_done;
  logic        r_err;

  logic        w_bad;
  logic [14:0] w_sh;
  logic [14:0] w_nx;
  logic [31:0] w_res;

  // Digits live in [14:7]; bits shifted out of them build the binary in [6:0].
  always_comb begin
    w_bad = (BCD[7:4] > 4'd9) || (BCD[3:0] > 4'd9);
    w_sh  = r_work >> 1;
    w_nx  = w_sh;
    if (w_sh[14:11] >= 4'd8)
      w_nx[14:11] = w_sh[14:11] - 4'd3;
    if (w_sh[10:7] >= 4'd8)
      w_nx[10:7] = w_sh[10:7] - 4'd3;
    w_res = {25'd0, w_nx[6:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_bin   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (w_bad) begin
              r_bin   <= '0;
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_work  <= {BCD, 7'b0};
              r_cnt   <= '0;
              r_err   <= 1'b0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= w_nx;
          r_cnt  <= r_cnt + 3'd1;
          if (r_cnt == 3'd6) begin
            r_bin   <= w_nx[6:0];
            r_err   <= (w_res > MAX_VALUE);
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bin  = r_bin;
  assign done = r_done;
  assign err  = r_err;
  assign busy = (r_state != IDLE);

endmodule
